// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared control-bundle layout and encodings for the 5-stage MIPS core
package cpu_pkg;

  // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[2:0]}
  localparam int CTRL_W          = 9;
  localparam int CTRL_REG_WRITE  = 8;
  localparam int CTRL_MEM_READ   = 7;
  localparam int CTRL_MEM_WRITE  = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_DST    = 3;
  localparam int CTRL_ALU_OP_LSB = 0;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_RTYPE = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - flags an ID instruction that reads the destination of a load sitting in EX
module load_use_detect
  import cpu_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         ex_valid,
  input  logic         ex_mem_read,
  input  logic [W-1:0] ex_rt,
  input  logic         id_valid,
  input  logic [W-1:0] id_rs,
  input  logic [W-1:0] id_rt,
  output logic         hz
);

  // A load targeting $0 never produces a value worth waiting for.
  assign hz = ex_valid & ex_mem_read & (ex_rt != W'(REG_ZERO)) & id_valid
            & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// rtl/id_ex_pipeline_reg.sv - ID->EX pipeline register with WB bypass, load-use stall and flush
module id_ex_pipeline_reg
  import cpu_pkg::*;
#(
  parameter int B   = 32,
  parameter int W   = 5,
  parameter int CW  = CTRL_W,
  parameter int SCW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic [B-1:0]   id_pc,
  input  logic [W-1:0]   id_rs,
  input  logic [W-1:0]   id_rt,
  input  logic [W-1:0]   id_rd,
  input  logic [B-1:0]   id_imm,
  input  logic [CW-1:0]  id_ctrl,
  input  logic [B-1:0]   rf_rdata1,
  input  logic [B-1:0]   rf_rdata2,
  input  logic           wb_wr_en,
  input  logic [W-1:0]   wb_waddr,
  input  logic [B-1:0]   wb_wdata,
  input  logic           flush,
  output logic           stall,
  output logic           ex_valid,
  output logic [B-1:0]   ex_pc,
  output logic [B-1:0]   ex_rdata1,
  output logic [B-1:0]   ex_rdata2,
  output logic [W-1:0]   ex_rs,
  output logic [W-1:0]   ex_rt,
  output logic [W-1:0]   ex_rd,
  output logic [B-1:0]   ex_imm,
  output logic [CW-1:0]  ex_ctrl,
  output logic [SCW-1:0] stall_cnt
);

  logic         hz;
  logic [B-1:0] op1;
  logic [B-1:0] op2;
  logic         bubble;

  load_use_detect #(.W(W)) u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEM_READ]),
    .ex_rt       (ex_rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .hz          (hz)
  );

  assign stall  = hz & ~flush;
  assign bubble = flush | stall | ~id_valid;

  // The register file writes on posedge, so a same-cycle WB write is not yet visible on rf_rdata.
  function automatic logic [B-1:0] select_operand(
    input logic [W-1:0] addr,
    input logic [B-1:0] rf_data,
    input logic         wr_en,
    input logic [W-1:0] waddr,
    input logic [B-1:0] wdata
  );
    if (addr == W'(REG_ZERO))
      return '0;
    else if (wr_en && (waddr == addr))
      return wdata;
    else
      return rf_data;
  endfunction

  always_comb begin
    op1 = select_operand(id_rs, rf_rdata1, wb_wr_en, wb_waddr, wb_wdata);
    op2 = select_operand(id_rt, rf_rdata2, wb_wr_en, wb_waddr, wb_wdata);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_pc     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_imm    <= '0;
      ex_ctrl   <= '0;
      stall_cnt <= '0;
    end else begin
      if (bubble) begin
        ex_valid  <= 1'b0;
        ex_pc     <= '0;
        ex_rdata1 <= '0;
        ex_rdata2 <= '0;
        ex_rs     <= '0;
        ex_rt     <= '0;
        ex_rd     <= '0;
        ex_imm    <= '0;
        ex_ctrl   <= '0;
      end else begin
        ex_valid  <= 1'b1;
        ex_pc     <= id_pc;
        ex_rdata1 <= op1;
        ex_rdata2 <= op2;
        ex_rs     <= id_rs;
        ex_rt     <= id_rt;
        ex_rd     <= id_rd;
        ex_imm    <= id_imm;
        ex_ctrl   <= id_ctrl;
      end
      if (stall && (stall_cnt != {SCW{1'b1}}))
        stall_cnt <= stall_cnt + SCW'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb/tb_id_ex_pipeline_reg.sv - randomized and directed checks of the ID->EX register against a reference model
module tb_id_ex_pipeline_reg;
  import cpu_pkg::*;

  localparam logic [8:0] C_LW  = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD};
  localparam logic [8:0] C_ADD = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_RTYPE};
  localparam int unsigned BIG_MAX   = 65535;
  localparam int unsigned SMALL_MAX = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_imm, rf_rdata1, rf_rdata2, wb_wdata;
  logic [4:0]  id_rs, id_rt, id_rd, wb_waddr;
  logic [8:0]  id_ctrl;
  logic        wb_wr_en, flush;

  logic        stall, ex_valid;
  logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [8:0]  ex_ctrl;
  logic [15:0] stall_cnt;

  logic        s_stall, s_ex_valid;
  logic [31:0] s_ex_pc, s_ex_rdata1, s_ex_rdata2, s_ex_imm;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
  logic [8:0]  s_ex_ctrl;
  logic [1:0]  s_stall_cnt;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [8:0]  ctrl;
  } ex_t;

  ex_t         m;
  int unsigned m_cnt, m_scnt;
  int          vectors, miscompares;
  logic [152:0] dut_vec, sdut_vec;

  assign dut_vec  = {ex_valid, ex_pc, ex_rdata1, ex_rdata2, ex_rs, ex_rt, ex_rd, ex_imm, ex_ctrl};
  assign sdut_vec = {s_ex_valid, s_ex_pc, s_ex_rdata1, s_ex_rdata2, s_ex_rs, s_ex_rt, s_ex_rd, s_ex_imm, s_ex_ctrl};

  always #5 clk = ~clk;

  id_ex_pipeline_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_wr_en(wb_wr_en), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
  );

  id_ex_pipeline_reg #(.SCW(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_wr_en(wb_wr_en), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flush(flush), .stall(s_stall),
    .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rdata1(s_ex_rdata1), .ex_rdata2(s_ex_rdata2), .ex_rs(s_ex_rs),
    .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_imm(s_ex_imm), .ex_ctrl(s_ex_ctrl), .stall_cnt(s_stall_cnt)
  );

  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (wb_wr_en && wb_waddr == a) return wb_wdata;
    return rf;
  endfunction

  function automatic logic model_stall();
    return m.v && m.ctrl[CTRL_MEM_READ] && m.rt != 5'd0 && id_valid
           && (m.rt == id_rs || m.rt == id_rt) && !flush;
  endfunction

  task automatic clock_cycle();
    logic st;
    ex_t  nxt;
    st  = model_stall();
    nxt = '0;
    if (!flush && !st && id_valid) begin
      nxt.v = 1'b1; nxt.pc = id_pc; nxt.imm = id_imm; nxt.ctrl = id_ctrl;
      nxt.rs = id_rs; nxt.rt = id_rt; nxt.rd = id_rd;
      nxt.r1 = operand(id_rs, rf_rdata1);
      nxt.r2 = operand(id_rt, rf_rdata2);
    end
    @(posedge clk);
    #1;
    m = nxt;
    if (st) begin
      if (m_cnt < BIG_MAX) m_cnt++;
      if (m_scnt < SMALL_MAX) m_scnt++;
    end
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [8:0] ctrl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_ctrl = ctrl;
    id_pc = $urandom; id_imm = $urandom; rf_rdata1 = $urandom; rf_rdata2 = $urandom;
  endtask

  task automatic model_clear();
    m = '0; m_cnt = 0; m_scnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; wb_wr_en = 1'b0; wb_waddr = '0; wb_wdata = '0;
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 9'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dut_vec !== 153'd0 || stall !== 1'b0 || stall_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset: ex=%h stall=%b cnt=%0d, need all zero", dut_vec, stall, stall_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_use();
    drive_id(1'b1, 5'd1, 5'd5, 5'd0, C_LW);
    clock_cycle();
    vectors++;
    if (dut_vec !== m || ex_valid !== 1'b1) begin
      miscompares++; $display("FAIL lw_enter: got %h need %h", dut_vec, m);
    end
    drive_id(1'b1, 5'd5, 5'd7, 5'd6, C_ADD);
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL load_use_stall: stall=%b need 1", stall);
    end
    clock_cycle();
    vectors++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || stall_cnt !== 16'd1 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL load_use_bubble: valid=%b ctrl=%h cnt=%0d stall=%b need 0/0/1/0", ex_valid, ex_ctrl, stall_cnt, stall);
    end
    rf_rdata1 = $urandom; rf_rdata2 = $urandom;
    clock_cycle();
    vectors++;
    if (dut_vec !== m || ex_rd !== 5'd6 || ex_valid !== 1'b1 || stall_cnt !== 16'd1) begin
      miscompares++; $display("FAIL load_use_add_enter: got %h cnt=%0d need %h cnt=1", dut_vec, stall_cnt, m);
    end
  endtask

  task automatic test_bypass();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 9'd0);
    clock_cycle();
    drive_id(1'b1, 5'd3, 5'd8, 5'd2, C_ADD);
    rf_rdata1 = 32'h0000_0011;
    wb_wr_en = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'hDEAD_BEEF;
    clock_cycle();
    wb_wr_en = 1'b0;
    vectors++;
    if (ex_rdata1 !== 32'hDEAD_BEEF || dut_vec !== m) begin
      miscompares++; $display("FAIL wb_bypass: rdata1=%h need deadbeef", ex_rdata1);
    end
  endtask

  task automatic test_zero_reg();
    drive_id(1'b1, 5'd0, 5'd4, 5'd2, C_ADD);
    rf_rdata1 = 32'hFFFF_FFFF;
    wb_wr_en = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'h0000_1234;
    clock_cycle();
    wb_wr_en = 1'b0;
    vectors++;
    if (ex_rdata1 !== 32'd0 || dut_vec !== m) begin
      miscompares++; $display("FAIL zero_reg: rdata1=%h need 0", ex_rdata1);
    end
  endtask

  task automatic test_flush_hazard();
    logic [15:0] cnt0;
    drive_id(1'b1, 5'd2, 5'd9, 5'd0, C_LW);
    clock_cycle();
    cnt0 = stall_cnt;
    drive_id(1'b1, 5'd9, 5'd1, 5'd4, C_ADD);
    flush = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++; $display("FAIL flush_hazard_stall: stall=%b need 0", stall);
    end
    clock_cycle();
    flush = 1'b0;
    vectors++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || stall_cnt !== cnt0 || dut_vec !== m) begin
      miscompares++; $display("FAIL flush_hazard_bubble: valid=%b ctrl=%h cnt=%0d need 0/0/%0d", ex_valid, ex_ctrl, stall_cnt, cnt0);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_id(1'b1, 5'd1, 5'd6, 5'd0, C_LW);
    clock_cycle();
    drive_id(1'b1, 5'd6, 5'd2, 5'd7, C_ADD);
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL mid_stall_setup: stall=%b need 1", stall);
    end
    rst_n = 1'b0;
    #1;
    model_clear();
    vectors++;
    if (dut_vec !== 153'd0 || stall !== 1'b0 || stall_cnt !== 16'd0 || s_stall_cnt !== 2'd0) begin
      miscompares++; $display("FAIL reset_mid_stall: ex=%h stall=%b cnt=%0d need zero", dut_vec, stall, stall_cnt);
    end
    #1;
    rst_n = 1'b1;
    clock_cycle();
    vectors++;
    if (dut_vec !== m || ex_valid !== 1'b1) begin
      miscompares++; $display("FAIL after_reset_load: got %h need %h", dut_vec, m);
    end
  endtask

  task automatic test_random();
    logic held;
    held = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (held) begin
        rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      end else begin
        drive_id($urandom_range(7, 0) != 0, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                 5'($urandom_range(31, 0)), 9'($urandom));
      end
      wb_wr_en = $urandom_range(1, 0) == 1;
      wb_waddr = 5'($urandom_range(7, 0));
      wb_wdata = $urandom;
      flush    = $urandom_range(7, 0) == 0;
      #1;
      held = model_stall();
      vectors++;
      if (stall !== held || s_stall !== held) begin
        miscompares++; $display("FAIL rand_stall[%0d]: stall=%b small=%b need %b", i, stall, s_stall, held);
      end
      clock_cycle();
      vectors++;
      if (dut_vec !== m || sdut_vec !== m || stall_cnt !== 16'(m_cnt) || s_stall_cnt !== 2'(m_scnt)) begin
        miscompares++;
        $display("FAIL rand_ex[%0d]: got %h cnt=%0d/%0d need %h cnt=%0d/%0d", i, dut_vec, stall_cnt, s_stall_cnt, m, m_cnt, m_scnt);
      end
    end
    flush = 1'b0; wb_wr_en = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_id(1'b1, 5'd1, 5'd9, 5'd0, C_LW);
      clock_cycle();
      drive_id(1'b1, 5'd2, 5'd9, 5'd3, C_ADD);
      #1;
      vectors++;
      if (stall !== 1'b1) begin
        miscompares++; $display("FAIL sat_stall[%0d]: stall=%b need 1", k, stall);
      end
      clock_cycle();
    end
    vectors++;
    if (s_stall_cnt !== 2'd3 || stall_cnt !== 16'd5) begin
      miscompares++; $display("FAIL saturate: small=%0d big=%0d need 3 and 5", s_stall_cnt, stall_cnt);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    test_reset();
    test_load_use();
    test_bypass();
    test_zero_reg();
    test_flush_hazard();
    test_reset_mid_stall();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
